mdu: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath, sitting in EX directly downstream of the mult/div instruction decoder. It consumes the decoded `Start`, `HiLo`, `WriteEnabled`, `MDU_Op` and `Add` controls plus the two register operands. It holds the architectural HI/LO registers, models multi-cycle latency with a `Busy` flag for the hazard unit, and returns HI or LO for `mfhi`/`mflo`.

---
 rtl/mdu_if.sv | 14 +
 rtl/mdu.sv | 76 +++++++
 tb/tb_mdu.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// mdu_if: decoded mult/div controls, operands and HI/LO read-back for the MDU
interface mdu_if;
  logic        Start;
  logic        HiLo;
  logic        WriteEnabled;
  logic [1:0]  MDU_Op;
  logic        Add;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] Out;
  modport master (output Start, HiLo, WriteEnabled, MDU_Op, Add, A, B, input Busy, Out);
  modport slave (input Start, HiLo, WriteEnabled, MDU_Op, Add, A, B, output Busy, Out);
endinterface

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit with HI/LO registers; define MDU_MADD_EN to enable madd
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [31:0] hi, lo, p_hi, p_lo, cnt, dv, q_s, r_s, q_u, r_u;
  logic [63:0] sa, sb, prod_s, prod_u, res, commit_val;
  logic add_go, launch, mt, commit, skip;
`ifdef MDU_MADD_EN
  logic acc;
  // remember whether the in-flight operation accumulates into HI/LO
  always_ff @(posedge clk or posedge reset)
    if (reset) acc <= 1'b0;
    else if (launch) acc <= !bus.Start;
  // madd request and accumulate-at-commit datapath
  always_comb begin
    add_go = bus.Add;
    commit_val = acc ? {hi, lo} + {p_hi, p_lo} : {p_hi, p_lo};
  end
`else
  // without madd, Add is ignored and commit is a plain load
  always_comb begin
    add_go = 1'b0;
    commit_val = {p_hi, p_lo};
  end
`endif
  // launch decode, next state and the result computed from the launch operands
  always_comb begin
    launch = state == IDLE && (bus.Start || add_go);
    mt = state == IDLE && !bus.Start && !add_go && bus.WriteEnabled;
    commit = state == RUN && cnt == 32'd1;
    state_n = launch ? RUN : commit ? IDLE : state;
    dv = bus.B == 32'd0 ? 32'd1 : bus.B;
    sa = {{32{bus.A[31]}}, bus.A};
    sb = {{32{bus.B[31]}}, bus.B};
    prod_s = sa * sb;
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    q_s = $signed(bus.A) / $signed(dv);
    r_s = $signed(bus.A) % $signed(dv);
    q_u = bus.A / dv;
    r_u = bus.A % dv;
    res = !bus.Start ? prod_s :
          bus.MDU_Op == 2'b11 ? {r_s, q_s} :
          bus.MDU_Op == 2'b10 ? {r_u, q_u} :
          bus.MDU_Op == 2'b01 ? prod_s : prod_u;
  end
  // state, latency counter, pending result and architectural HI/LO
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= 32'd0;
      hi <= 32'd0;
      lo <= 32'd0;
      p_hi <= 32'd0;
      p_lo <= 32'd0;
      skip <= 1'b0;
    end else begin
      state <= state_n;
      if (launch) begin
        cnt <= bus.Start && bus.MDU_Op[1] ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
        skip <= bus.Start && bus.MDU_Op[1] && bus.B == 32'd0;
        {p_hi, p_lo} <= res;
      end else if (state == RUN) cnt <= cnt - 32'd1;
      if (commit && !skip) {hi, lo} <= commit_val;
      if (mt && !bus.HiLo) hi <= bus.A;
      if (mt && bus.HiLo) lo <= bus.A;
    end
  assign bus.Busy = state == RUN;
  assign bus.Out = bus.HiLo ? lo : hi;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized self-checking bench for mdu against an arithmetic HI/LO model
module tb_mdu;
`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;
  mdu_if bus();
  mdu dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [31:0] eh, input logic [31:0] el);
    bus.HiLo = 1'b0;
    #1 check({tag, "_hi"}, bus.Out, eh);
    bus.HiLo = 1'b1;
    #1 check({tag, "_lo"}, bus.Out, el);
  endtask

  task automatic mdl(input bit start, input bit add, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    int sq, sr;
    sp = longint'($signed(a)) * longint'($signed(b));
    if (start) begin
      if (op == 2'b11 && b != 0) begin
        sq = int'($signed(a)) / int'($signed(b));
        sr = int'($signed(a)) % int'($signed(b));
        lo_m = sq;
        hi_m = sr;
      end else if (op == 2'b10 && b != 0) begin
        lo_m = a / b;
        hi_m = a % b;
      end else if (op == 2'b01) {hi_m, lo_m} = sp;
      else if (op == 2'b00) {hi_m, lo_m} = {32'd0, a} * {32'd0, b};
    end else if (add && MADD_EN) {hi_m, lo_m} = {hi_m, lo_m} + sp;
  endtask

  task automatic run_op(input bit start, input bit add, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
    int n, exp_n;
    exp_n = start ? (op[1] ? 10 : 5) : (add && MADD_EN) ? 5 : 0;
    @(negedge clk);
    bus.Start = start;
    bus.Add = add;
    bus.MDU_Op = op;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.Add = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.Start = 1'b0;
      bus.WriteEnabled = 1'b0;
      if (!bus.Busy) break;
      n++;
      if (inject && n == 2) begin
        bus.Start = 1'b1;
        bus.MDU_Op = 2'b00;
        bus.A = $urandom;
        bus.B = $urandom;
        bus.WriteEnabled = 1'b1;
        bus.HiLo = 1'b1;
      end
    end
    check("busy_len", n, exp_n);
    mdl(start, add, op, a, b);
    check_regs("op", hi_m, lo_m);
  endtask

  task automatic move_to(input bit sel_lo, input logic [31:0] a);
    @(negedge clk);
    bus.WriteEnabled = 1'b1;
    bus.HiLo = sel_lo;
    bus.A = a;
    @(negedge clk);
    bus.WriteEnabled = 1'b0;
    if (sel_lo) lo_m = a;
    else hi_m = a;
    check("mt_out", bus.Out, a);
  endtask

  initial begin
    logic [1:0] op;
    logic [31:0] a, b;
    int n;
    bus.Start = 1'b0;
    bus.Add = 1'b0;
    bus.WriteEnabled = 1'b0;
    bus.HiLo = 1'b0;
    bus.MDU_Op = 2'b00;
    bus.A = 32'd0;
    bus.B = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check_regs("rst", 32'd0, 32'd0);
    run_op(1, 0, 2'b01, 32'hFFFFFFFF, 32'd2, 0);
    check_regs("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op(1, 0, 2'b00, 32'hFFFFFFFF, 32'd2, 0);
    check_regs("multu", 32'h00000001, 32'hFFFFFFFE);
    run_op(1, 0, 2'b11, 32'hFFFFFFF9, 32'd2, 0);
    check_regs("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(1, 0, 2'b10, 32'd7, 32'd2, 0);
    check_regs("divu", 32'd1, 32'd3);
    move_to(0, 32'h12345678);
    move_to(1, 32'hCAFEF00D);
    run_op(1, 0, 2'b11, 32'd99, 32'd0, 0);
    check_regs("div0", 32'h12345678, 32'hCAFEF00D);
    move_to(0, 32'd0);
    move_to(1, 32'd5);
    run_op(0, 1, 2'b00, 32'd3, 32'd4, 0);
    if (MADD_EN) check_regs("madd1", 32'd0, 32'd17);
    else check_regs("madd_off", 32'd0, 32'd5);
    move_to(1, 32'd0);
    run_op(0, 1, 2'b00, 32'hFFFFFFFF, 32'd1, 0);
    run_op(1, 0, 2'b01, 32'd1234, 32'hFFFF0000, 1);
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 100);
      b = $urandom_range(0, 5) == 0 ? 32'd0 : $urandom_range(0, 1) ? $urandom : $urandom_range(1, 20);
      if (op == 2'b11 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      case ($urandom_range(0, 5))
        0: move_to($urandom_range(0, 1) == 1, $urandom);
        1: run_op(0, 1, op, a, b, 0);
        default: run_op(1, 0, op, a, b, i % 7 == 0);
      endcase
    end
    run_op(1, 0, 2'b10, 32'd1000, 32'd7, 0);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.MDU_Op = 2'b11;
    bus.A = 32'd500;
    bus.B = 32'd3;
    repeat (3) @(negedge clk);
    bus.Start = 1'b0;
    check("pre_rst_busy", {31'd0, bus.Busy}, 32'd1);
    reset = 1'b1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    #1 check("rst_mid_busy", {31'd0, bus.Busy}, 32'd0);
    check_regs("rst_mid", 32'd0, 32'd0);
    bus.Start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.Start = 1'b0;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.Busy) n++;
    end
    check("post_rst_busy", n, 32'd0);
    check_regs("post_rst", 32'd0, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
